// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data-cache controller.
// Loads miss by fetching a whole line; every store becomes a single-word memory write.
module dcache_ctrl #(
    parameter int TAG_W = 4,
    parameter int IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cpu_req_in,
    input  logic                   cpu_we_in,
    input  logic [11:0]            cpu_addr_in,
    input  logic [31:0]            cpu_wdata_in,
    output logic                   cpu_ready_out,
    output logic                   cpu_done_out,
    output logic [31:0]            cpu_rdata_out,
    output logic                   r_mem_req_out,
    output logic                   w_mem_req_out,
    output logic [TAG_W+IDX_W-1:0] mem_addr_out,
    output logic [1:0]             word_id_out,
    output logic                   mem_wr_en_out,
    output logic [31:0]            data_mem_wr_data_out,
    input  logic                   mem_comp_in,
    input  logic [127:0]           mem_data_in,
    output logic [15:0]            hit_cnt_out,
    output logic [15:0]            miss_cnt_out
);
    localparam int LINES = 1 << IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

    state_t                   state_q;
    logic [LINES-1:0]         valid_q;
    logic [TAG_W-1:0]         tag_q [LINES];
    logic [127:0]             data_q [LINES];
    logic [9:0]               addr_q;
    logic [31:0]              wdata_q;
    logic                     we_q;
    logic                     done_q, r_req_q, w_req_q, wr_en_q;
    logic [31:0]              rdata_q, wr_data_q;
    logic [TAG_W+IDX_W-1:0]   mem_addr_q;
    logic [1:0]               word_id_q;
    logic [15:0]              hit_cnt_q, miss_cnt_q;
    logic [IDX_W-1:0]         idx;
    logic [TAG_W-1:0]         tag;
    logic [1:0]               word;
    logic                     hit;
    logic                     unused_byte;

    assign unused_byte = ^cpu_addr_in[1:0];
    assign word = addr_q[1:0];
    assign idx  = addr_q[2 +: IDX_W];
    assign tag  = addr_q[2+IDX_W +: TAG_W];
    assign hit  = valid_q[idx] && tag_q[idx] == tag;

    assign cpu_ready_out        = state_q == IDLE;
    assign cpu_done_out         = done_q;
    assign cpu_rdata_out        = rdata_q;
    assign r_mem_req_out        = r_req_q;
    assign w_mem_req_out        = w_req_q;
    assign mem_addr_out         = mem_addr_q;
    assign word_id_out          = word_id_q;
    assign mem_wr_en_out        = wr_en_q;
    assign data_mem_wr_data_out = wr_data_q;
    assign hit_cnt_out          = hit_cnt_q;
    assign miss_cnt_out         = miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            r_req_q    <= 1'b0;
            w_req_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            mem_addr_q <= '0;
            word_id_q  <= '0;
            wr_data_q  <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            // Memory-side outputs are single-cycle pulses and idle at zero.
            done_q     <= 1'b0;
            rdata_q    <= '0;
            r_req_q    <= 1'b0;
            w_req_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            mem_addr_q <= '0;
            word_id_q  <= '0;
            wr_data_q  <= '0;
            case (state_q)
                IDLE: if (cpu_req_in) begin
                    addr_q  <= cpu_addr_in[11:2];
                    wdata_q <= cpu_wdata_in;
                    we_q    <= cpu_we_in;
                    state_q <= LOOKUP;
                end
                LOOKUP: begin
                    hit_cnt_q  <= hit_cnt_q + 16'(hit && hit_cnt_q != 16'hFFFF);
                    miss_cnt_q <= miss_cnt_q + 16'(!hit && miss_cnt_q != 16'hFFFF);
                    if (!we_q && hit) begin
                        rdata_q <= data_q[idx][{word, 5'd0} +: 32];
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (!we_q) begin
                        r_req_q    <= 1'b1;
                        mem_addr_q <= {tag, idx};
                        state_q    <= RD_REQ;
                    end else begin
                        if (hit) data_q[idx][{word, 5'd0} +: 32] <= wdata_q;
                        w_req_q    <= 1'b1;
                        wr_en_q    <= 1'b1;
                        mem_addr_q <= {tag, idx};
                        word_id_q  <= word;
                        wr_data_q  <= wdata_q;
                        state_q    <= WR_REQ;
                    end
                end
                RD_REQ: state_q <= RD_WAIT;
                RD_WAIT: if (mem_comp_in) begin
                    data_q[idx]  <= mem_data_in;
                    tag_q[idx]   <= tag;
                    valid_q[idx] <= 1'b1;
                    rdata_q      <= mem_data_in[{word, 5'd0} +: 32];
                    done_q       <= 1'b1;
                    state_q      <= IDLE;
                end
                WR_REQ: state_q <= WR_WAIT;
                WR_WAIT: if (mem_comp_in) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed scenarios for dcache_ctrl against a line-memory model.
// Memory word w of line L starts as 0xA000_0000 | L<<8 | w.
module tb_dcache_ctrl;
    logic         clk = 0, reset_n = 0;
    logic         cpu_req_in = 0, cpu_we_in = 0, mem_comp_in = 0;
    logic [11:0]  cpu_addr_in = 0;
    logic [31:0]  cpu_wdata_in = 0;
    logic [127:0] mem_data_in = 0;
    logic         cpu_ready_out, cpu_done_out, r_mem_req_out, w_mem_req_out, mem_wr_en_out;
    logic [31:0]  cpu_rdata_out, data_mem_wr_data_out;
    logic [7:0]   mem_addr_out;
    logic [1:0]   word_id_out;
    logic [15:0]  hit_cnt_out, miss_cnt_out;

    dcache_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req_in(cpu_req_in), .cpu_we_in(cpu_we_in), .cpu_addr_in(cpu_addr_in),
        .cpu_wdata_in(cpu_wdata_in), .cpu_ready_out(cpu_ready_out), .cpu_done_out(cpu_done_out),
        .cpu_rdata_out(cpu_rdata_out), .r_mem_req_out(r_mem_req_out), .w_mem_req_out(w_mem_req_out),
        .mem_addr_out(mem_addr_out), .word_id_out(word_id_out), .mem_wr_en_out(mem_wr_en_out),
        .data_mem_wr_data_out(data_mem_wr_data_out), .mem_comp_in(mem_comp_in),
        .mem_data_in(mem_data_in), .hit_cnt_out(hit_cnt_out), .miss_cnt_out(miss_cnt_out)
    );

    always #5 clk = ~clk;

    logic [127:0] model [256];
    int checks = 0, errors = 0;
    int o_done, o_rreq, o_wreq, o_nreq;
    logic [31:0] o_rdata, o_wdata;
    logic [7:0]  o_addr;
    logic [1:0]  o_word;
    logic        o_wren, o_ready, o_leak;

    // Issues one access at the current negedge (cycle 0) and records what the DUT does.
    task automatic access(input logic we, input logic [11:0] a, input logic [31:0] d,
                          input int dly, input int max_c, input logic keep);
        int rc;
        rc = -1; o_done = -1; o_rreq = -1; o_wreq = -1; o_nreq = 0;
        o_leak = 0; o_wren = 0; o_rdata = 'x; o_wdata = 0; o_addr = 0; o_word = 0; o_ready = 0;
        cpu_req_in = 1; cpu_we_in = we; cpu_addr_in = a; cpu_wdata_in = d;
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clk);
            cpu_req_in = 0;
            if (r_mem_req_out) begin o_nreq++; o_rreq = c; rc = c; o_addr = mem_addr_out; end
            if (w_mem_req_out) begin
                o_nreq++; o_wreq = c; rc = c; o_addr = mem_addr_out; o_word = word_id_out;
                o_wren = mem_wr_en_out; o_wdata = data_mem_wr_data_out;
                model[mem_addr_out][{word_id_out, 5'd0} +: 32] = data_mem_wr_data_out;
            end
            if (!r_mem_req_out && !w_mem_req_out &&
                (mem_addr_out != 0 || word_id_out != 0 || data_mem_wr_data_out != 0 || mem_wr_en_out))
                o_leak = 1;
            if (cpu_done_out) begin
                o_done = c; o_rdata = cpu_rdata_out; o_ready = cpu_ready_out;
                if (!keep) mem_comp_in = 0;
                break;
            end
            if (rc >= 0 && c >= rc + 1 + dly) begin mem_comp_in = 1; mem_data_in = model[o_addr]; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (cpu_ready_out !== 1) begin errors++; $display("FAIL rst_ready: got %0b want 1", cpu_ready_out); end
        checks++; if ({cpu_done_out, r_mem_req_out, w_mem_req_out, mem_wr_en_out} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {cpu_done_out, r_mem_req_out, w_mem_req_out, mem_wr_en_out}); end
        checks++; if ({hit_cnt_out, miss_cnt_out} !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %h want 0", {hit_cnt_out, miss_cnt_out}); end
        checks++; if ({mem_addr_out, word_id_out, data_mem_wr_data_out, cpu_rdata_out} !== 74'h0) begin errors++; $display("FAIL rst_data: got %h want 0", {mem_addr_out, word_id_out, data_mem_wr_data_out, cpu_rdata_out}); end
        reset_n = 1;
    endtask

    task automatic test_cold_miss();
        access(0, 12'h104, 0, 0, 20, 0);
        checks++; if (o_rreq !== 2 || o_nreq !== 1) begin errors++; $display("FAIL miss_rreq: got cyc %0d n %0d want cyc 2 n 1", o_rreq, o_nreq); end
        checks++; if (o_addr !== 8'h10) begin errors++; $display("FAIL miss_addr: got %h want 10", o_addr); end
        checks++; if (o_done !== 4) begin errors++; $display("FAIL miss_done: got %0d want 4", o_done); end
        checks++; if (o_rdata !== 32'hA000_1001) begin errors++; $display("FAIL miss_rdata: got %h want a0001001", o_rdata); end
        checks++; if (miss_cnt_out !== 1 || hit_cnt_out !== 0) begin errors++; $display("FAIL miss_cnt: got h %0d m %0d want h 0 m 1", hit_cnt_out, miss_cnt_out); end
        checks++; if (o_ready !== 1) begin errors++; $display("FAIL miss_ready_at_done: got %0b want 1", o_ready); end
        checks++; if (o_leak !== 0) begin errors++; $display("FAIL miss_idle_zero: got %0b want 0", o_leak); end
    endtask

    task automatic test_load_hit();
        access(0, 12'h108, 0, 0, 20, 0);
        checks++; if (o_done !== 2) begin errors++; $display("FAIL hit_done: got %0d want 2", o_done); end
        checks++; if (o_rdata !== 32'hA000_1002) begin errors++; $display("FAIL hit_rdata: got %h want a0001002", o_rdata); end
        checks++; if (o_nreq !== 0) begin errors++; $display("FAIL hit_noreq: got %0d want 0", o_nreq); end
        checks++; if (hit_cnt_out !== 1 || miss_cnt_out !== 1) begin errors++; $display("FAIL hit_cnt: got h %0d m %0d want h 1 m 1", hit_cnt_out, miss_cnt_out); end
    endtask

    task automatic test_store_hit();
        access(1, 12'h104, 32'hDEADBEEF, 0, 20, 0);
        checks++; if (o_wreq !== 2 || o_nreq !== 1) begin errors++; $display("FAIL sthit_wreq: got cyc %0d n %0d want cyc 2 n 1", o_wreq, o_nreq); end
        checks++; if ({o_addr, o_word, o_wren} !== {8'h10, 2'd1, 1'b1}) begin errors++; $display("FAIL sthit_req: got addr %h word %0d en %0b want 10 1 1", o_addr, o_word, o_wren); end
        checks++; if (o_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sthit_wdata: got %h want deadbeef", o_wdata); end
        checks++; if (o_done !== 4 || o_rdata !== 0) begin errors++; $display("FAIL sthit_done: got cyc %0d rdata %h want 4 0", o_done, o_rdata); end
        access(0, 12'h104, 0, 0, 20, 0);
        checks++; if (o_done !== 2 || o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sthit_reload: got cyc %0d %h want 2 deadbeef", o_done, o_rdata); end
        checks++; if (hit_cnt_out !== 3 || miss_cnt_out !== 1) begin errors++; $display("FAIL sthit_cnt: got h %0d m %0d want h 3 m 1", hit_cnt_out, miss_cnt_out); end
    endtask

    task automatic test_store_miss();
        access(1, 12'h204, 32'h12345678, 0, 20, 0);
        checks++; if ({o_addr, o_word, o_wren} !== {8'h20, 2'd1, 1'b1} || o_wreq !== 2) begin errors++; $display("FAIL stmiss_req: got addr %h word %0d en %0b cyc %0d want 20 1 1 2", o_addr, o_word, o_wren, o_wreq); end
        checks++; if (o_done !== 4) begin errors++; $display("FAIL stmiss_done: got %0d want 4", o_done); end
        access(0, 12'h204, 0, 0, 20, 0);
        checks++; if (o_rreq !== 2 || o_addr !== 8'h20) begin errors++; $display("FAIL stmiss_noalloc: got cyc %0d addr %h want 2 20", o_rreq, o_addr); end
        checks++; if (o_rdata !== 32'h12345678) begin errors++; $display("FAIL stmiss_rdata: got %h want 12345678", o_rdata); end
        checks++; if (hit_cnt_out !== 3 || miss_cnt_out !== 3) begin errors++; $display("FAIL stmiss_cnt: got h %0d m %0d want h 3 m 3", hit_cnt_out, miss_cnt_out); end
    endtask

    task automatic test_conflict();
        access(0, 12'h904, 0, 0, 20, 0);
        checks++; if (o_rreq !== 2 || o_addr !== 8'h90 || o_rdata !== 32'hA000_9001) begin errors++; $display("FAIL evict_miss: got cyc %0d addr %h %h want 2 90 a0009001", o_rreq, o_addr, o_rdata); end
        access(0, 12'h104, 0, 0, 20, 0);
        checks++; if (o_rreq !== 2 || o_addr !== 8'h10) begin errors++; $display("FAIL evict_reload: got cyc %0d addr %h want 2 10", o_rreq, o_addr); end
        checks++; if (o_rdata !== 32'hDEADBEEF || o_done !== 4) begin errors++; $display("FAIL evict_rdata: got %h cyc %0d want deadbeef 4", o_rdata, o_done); end
    endtask

    task automatic test_slow_comp();
        access(1, 12'h30C, 32'hCAFEF00D, 2, 20, 0);
        checks++; if (o_wreq !== 2 || o_word !== 3 || o_addr !== 8'h30) begin errors++; $display("FAIL slow_req: got cyc %0d word %0d addr %h want 2 3 30", o_wreq, o_word, o_addr); end
        checks++; if (o_done !== 6) begin errors++; $display("FAIL slow_done: got %0d want 6", o_done); end
        checks++; if (miss_cnt_out !== 6) begin errors++; $display("FAIL slow_cnt: got %0d want 6", miss_cnt_out); end
    endtask

    task automatic test_comp_level();
        access(0, 12'h308, 0, 0, 20, 1);
        checks++; if (o_done !== 4 || o_rdata !== 32'hA000_3002) begin errors++; $display("FAIL level_load: got cyc %0d %h want 4 a0003002", o_done, o_rdata); end
        access(1, 12'h308, 32'h0BADCAFE, 0, 20, 1);
        checks++; if (o_wreq !== 2 || o_done !== 4) begin errors++; $display("FAIL level_store: got wreq %0d done %0d want 2 4", o_wreq, o_done); end
        mem_comp_in = 0;
        access(0, 12'h308, 0, 0, 20, 0);
        checks++; if (o_done !== 2 || o_rdata !== 32'h0BADCAFE) begin errors++; $display("FAIL level_hit: got cyc %0d %h want 2 0badcafe", o_done, o_rdata); end
        checks++; if (hit_cnt_out !== 5 || miss_cnt_out !== 7) begin errors++; $display("FAIL level_cnt: got h %0d m %0d want h 5 m 7", hit_cnt_out, miss_cnt_out); end
    endtask

    task automatic test_reset_rd_wait();
        int seen;
        access(0, 12'h104, 0, 100, 3, 0);
        reset_n = 0;
        @(negedge clk);
        checks++; if (cpu_ready_out !== 1 || cpu_done_out !== 0) begin errors++; $display("FAIL rstwait_state: got ready %0b done %0b want 1 0", cpu_ready_out, cpu_done_out); end
        checks++; if (hit_cnt_out !== 0 || miss_cnt_out !== 0) begin errors++; $display("FAIL rstwait_cnt: got h %0d m %0d want 0 0", hit_cnt_out, miss_cnt_out); end
        reset_n = 1;
        mem_comp_in = 1;
        seen = 0;
        repeat (3) begin @(negedge clk); seen |= int'(cpu_done_out | r_mem_req_out); end
        mem_comp_in = 0;
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstwait_quiet: got %0d want 0", seen); end
        access(0, 12'h104, 0, 0, 20, 0);
        checks++; if (o_rreq !== 2 || o_addr !== 8'h10 || miss_cnt_out !== 1) begin errors++; $display("FAIL rstwait_remiss: got cyc %0d addr %h m %0d want 2 10 1", o_rreq, o_addr, miss_cnt_out); end
        checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rstwait_rdata: got %h want deadbeef", o_rdata); end
    endtask

    initial begin
        for (int l = 0; l < 256; l++)
            for (int w = 0; w < 4; w++)
                model[l][32*w +: 32] = 32'hA000_0000 | (32'(l) << 8) | 32'(w);
        @(negedge clk);
        test_reset();
        test_cold_miss();
        test_load_hit();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_slow_comp();
        test_comp_level();
        test_reset_rd_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
